// File: rtl/palindrome_pkg.sv
`default_nettype none
// ============================================================================
// Module      : palindrome_pkg
// Description : Shared widths and state encoding for the palindrome datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package palindrome_pkg;

  localparam int SYM_W    = 4;
  localparam int NUM_SYMS = 16;
  localparam int SEQ_W    = SYM_W * NUM_SYMS;
  localparam int LEN_W    = 4;

  // Loader FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/nibble_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : nibble_stream_if
// Description : Symbol stream valid/ready bus between loader and detector.
// Revision    : 1.0 - initial release
// ============================================================================
interface nibble_stream_if;
  import palindrome_pkg::*;

  logic [SYM_W-1:0] sym_out;
  logic             sym_valid;
  logic             sym_ready;
  logic             sym_last;
  logic [LEN_W-1:0] sym_idx;

  // Producer side
  modport master (
    output sym_out,
    output sym_valid,
    output sym_last,
    output sym_idx,
    input  sym_ready
  );

  // Consumer side
  modport slave (
    input  sym_out,
    input  sym_valid,
    input  sym_last,
    input  sym_idx,
    output sym_ready
  );

endinterface
`default_nettype wire

// File: rtl/nibble_stream_loader.sv
`default_nettype none
// ============================================================================
// Module      : nibble_stream_loader
// Description : Captures a packed symbol sequence on start and streams it one
//               nibble per accepted transfer, most-significant nibble first.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_stream_loader
  import palindrome_pkg::*;
(
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             start,
  input  wire logic [SEQ_W-1:0] seq_in,
  input  wire logic [LEN_W-1:0] len_in,
  nibble_stream_if.master       sym,
  output      logic             busy,
  output      logic             done,
  output      logic             start_err
);

  state_t           r_state;
  logic [SEQ_W-1:0] r_shift;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_idx;
  logic             r_busy;
  logic             r_valid;
  logic             r_last;
  logic             r_done;
  logic             r_err;

  state_t           w_state_nxt;
  logic [SEQ_W-1:0] w_shift_nxt;
  logic [LEN_W-1:0] w_len_nxt;
  logic [LEN_W-1:0] w_idx_nxt;
  logic             w_busy_nxt;
  logic             w_err_nxt;
  logic             w_xfer;
  logic             w_last;

  // r_valid is a register, so sym_ready never reaches sym_valid combinationally
  assign w_xfer = r_valid && sym.sym_ready;
  assign w_last = (r_idx == (r_len - LEN_W'(1)));

  // Next-state and datapath updates; everything holds unless a case changes it
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_len_nxt   = r_len;
    w_idx_nxt   = r_idx;
    w_busy_nxt  = r_busy;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_shift_nxt = seq_in;
          w_len_nxt   = len_in;
          w_idx_nxt   = '0;
          w_busy_nxt  = 1'b1;
          // An empty sequence still produces a done pulse, just no symbols
          w_state_nxt = (len_in == '0) ? FINISH : STREAM;
        end
      end
      STREAM: begin
        w_err_nxt = start;
        if (w_xfer) begin
          if (w_last) begin
            w_state_nxt = FINISH;
            w_busy_nxt  = 1'b0;
          end else begin
            w_shift_nxt = {r_shift[SEQ_W-SYM_W-1:0], {SYM_W{1'b0}}};
            w_idx_nxt   = r_idx + LEN_W'(1);
          end
        end
      end
      FINISH: begin
        w_err_nxt   = start;
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, datapath and registered output flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_len   <= w_len_nxt;
      r_idx   <= w_idx_nxt;
      r_busy  <= w_busy_nxt;
      r_valid <= (w_state_nxt == STREAM);
      r_last  <= (w_state_nxt == STREAM) && (w_idx_nxt == (w_len_nxt - LEN_W'(1)));
      r_done  <= (w_state_nxt == FINISH);
      r_err   <= w_err_nxt;
    end
  end

  assign sym.sym_out   = r_shift[SEQ_W-1 -: SYM_W];
  assign sym.sym_valid = r_valid;
  assign sym.sym_last  = r_last;
  assign sym.sym_idx   = r_idx;
  assign busy          = r_busy;
  assign done          = r_done;
  assign start_err     = r_err;

endmodule
`default_nettype wire

// File: doc/nibble_stream_loader.md
# nibble_stream_loader

Upstream feeder for the palindrome detector. Captures a packed 64-bit symbol sequence and a length on a start pulse, then streams it one 4-bit symbol per accepted transfer, most-significant nibble first, over a valid/ready handshake. Replaces the free-running input counter in the top level with a controlled, restartable source that tells the detector exactly when each symbol is real and which one is last.

## Interface
- SYM_W, 4, symbol width in bits
- NUM_SYMS, 16, symbols held in the packed sequence; SEQ_W = SYM_W*NUM_SYMS = 64
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- start  input  1  one-cycle request to capture seq_in/len_in and begin streaming
- seq_in  input  64  packed sequence; symbol 0 = seq_in[63:60]
- len_in  input  4  number of symbols to stream, 0..15
- sym_out  output  4  current symbol
- sym_valid  output  1  sym_out holds a valid symbol
- sym_ready  input  1  downstream accepts sym_out this cycle
- sym_last  output  1  current symbol is the final one (qualified by sym_valid)
- sym_idx  output  4  index of current symbol, 0-based
- busy  output  1  high from capture until the final transfer completes
- done  output  1  one-cycle pulse when the stream is finished
- start_err  output  1  one-cycle pulse when start arrives while busy

## Operation
- States: IDLE, STREAM, FINISH.
- IDLE: busy=0, sym_valid=0. On start=1: latch seq_in into shift register, len_in into len_q, idx=0, set busy. If len_in=0 go to FINISH (no symbols emitted), else go to STREAM.
- STREAM: sym_valid=1, sym_out = shift[63:60], sym_idx=idx, sym_last = (idx == len_q-1). Transfer = sym_valid & sym_ready. On transfer and not last: shift left by 4 (zero-fill), idx+1. On transfer and last: go to FINISH. Without ready, sym_out/sym_idx/sym_last are held stable.
- FINISH: busy=0, done=1 for exactly one cycle, next state IDLE.
- start while in STREAM or FINISH: ignored, sequence unchanged, start_err=1 for one cycle.
- seq_in/len_in are only sampled on an accepted start; later changes have no effect on an active stream.
- Only nibbles 0..len_q-1 are ever emitted; nibble 15 is unreachable (len max 15), matching the detector's 4-bit length.

## Timing
- Reset (reset=0 on a rising edge): state=IDLE; sym_out=0, sym_valid=0, sym_last=0, sym_idx=0, busy=0, done=0, start_err=0; shift and len_q cleared. Reset mid-stream aborts with no done pulse.
- start sampled at edge N → sym_valid=1 with symbol 0 from edge N+1 (1-cycle latency). busy=1 from N+1.
- With sym_ready held high: one symbol per cycle; len L streams on edges N+1..N+L; done pulses in cycle N+L+1; start accepted again at edge N+L+2.
- len=0: busy=1 in cycle N+1 only, done in cycle N+1; sym_valid never asserted.
- All outputs registered; no combinational path from sym_ready to sym_valid.
- start and reset coincident: reset wins.

## Structure
- Shared package palindrome_pkg: SYM_W, NUM_SYMS, SEQ_W, LEN_W=4, state enum {IDLE, STREAM, FINISH}.
- Single flat module; no sub-module needed. Shift register, index counter and FSM in one block.

## Test plan
- seq_in=64'h1234_5432_1000_0000, len=9, ready=1 → symbols 1,2,3,4,5,4,3,2,1 on consecutive cycles, sym_last only on idx 8, done one cycle later.
- Same stream with ready toggled 1,0,0,1,… → each symbol held stable while ready=0, no skipped or repeated symbols, order unchanged.
- len=0, start → no sym_valid, done pulse in the cycle after start, busy high exactly one cycle.
- start again at idx 3 of a len=7 stream with a different seq_in → start_err pulse, original stream completes unchanged.
- reset=0 at idx 5 of len=12 → all outputs zero the next cycle, no done; new start afterwards streams from symbol 0.
- seq_in=64'hFEDC_BA98_7654_3210, len=15 → symbols F down to 1, sym_idx 0..14, nibble 0 never emitted.
